// File: rtl/jk_reg_loader.sv
// Write-side controller for a negedge JK bank: computes J/K excitation, drives it for one cycle, reads back, retries.
// Define JKLD_TOGGLE_EN for toggle-form excitation (J = K = target ^ q_fb); otherwise set/reset form.
module jk_reg_loader #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       retry_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [3:0]       retry_q, retry_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

`ifdef JKLD_TOGGLE_EN
  function automatic logic [WIDTH-1:0] exc_j(input logic [WIDTH-1:0] tgt,
                                             input logic [WIDTH-1:0] q);
    return tgt ^ q;
  endfunction

  function automatic logic [WIDTH-1:0] exc_k(input logic [WIDTH-1:0] tgt,
                                             input logic [WIDTH-1:0] q);
    return tgt ^ q;
  endfunction
`else
  function automatic logic [WIDTH-1:0] exc_j(input logic [WIDTH-1:0] tgt,
                                             input logic [WIDTH-1:0] q);
    return tgt & ~q;
  endfunction

  function automatic logic [WIDTH-1:0] exc_k(input logic [WIDTH-1:0] tgt,
                                             input logic [WIDTH-1:0] q);
    return ~tgt & q;
  endfunction
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      j_q      <= '0;
      k_q      <= '0;
      retry_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      j_q      <= j_d;
      k_q      <= k_d;
      retry_q  <= retry_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // J/K default to hold so excitation lasts exactly the one DRIVE cycle.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    j_d      = '0;
    k_d      = '0;
    retry_d  = retry_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (din_valid) begin
          target_d = din;
          retry_d  = '0;
          j_d      = exc_j(din, q_fb);
          k_d      = exc_k(din, q_fb);
          state_d  = S_DRIVE;
        end
      end
      S_DRIVE: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (q_fb == target_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + 4'd1;
          j_d     = exc_j(target_q, q_fb);
          k_d     = exc_k(target_q, q_fb);
          state_d = S_DRIVE;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign din_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign J         = j_q;
  assign K         = k_q;
  assign done      = done_q;
  assign err       = err_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_jk_reg_loader.sv
// Bench for jk_reg_loader: behavioural JK bank with fault injection, outcome scoreboard and excitation monitor.
`timescale 1ns/1ps
module tb_jk_reg_loader;
  localparam int W  = 8;
  localparam int MR = 3;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, busy, done, err;
  logic [W-1:0] q_fb, J, K;
  logic [3:0]   retry_cnt;

  logic [W-1:0] bank_q = '0;
  logic [W-1:0] load_val = '0;
  bit           load_req = 1'b0, load_ack = 1'b0;
  bit           stuck = 1'b0, freeze_en = 1'b0;
  int           freeze_at = 0, drive_n = 0;
  logic [W-1:0] cur_tgt = '0;
  int           cyc = 0;
  int           checks = 0, errors = 0;

  typedef struct {
    bit           is_err;
    int           retries;
    int           lat;
    logic [W-1:0] fin;
    int           acc;
  } exp_t;
  exp_t sb[$];

  jk_reg_loader #(.WIDTH(W), .MAX_RETRY(MR)) dut (
    .CLK(CLK), .RST(RST), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .q_fb(q_fb), .J(J), .K(K), .busy(busy), .done(done), .err(err), .retry_cnt(retry_cnt)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  assign q_fb = stuck ? 8'h01 : bank_q;

  // Negedge JK bank; freeze_en holds bit 0 on one chosen drive to emulate a transient write failure.
  always @(negedge CLK) begin
    logic [W-1:0] nq;
    if (load_req != load_ack) begin
      bank_q   <= load_val;
      load_ack <= load_req;
    end else begin
      nq = bank_q;
      for (int i = 0; i < W; i++) begin
        case ({J[i], K[i]})
          2'b10:   nq[i] = 1'b1;
          2'b01:   nq[i] = 1'b0;
          2'b11:   nq[i] = ~bank_q[i];
          default: nq[i] = bank_q[i];
        endcase
      end
      if ((J | K) != '0) begin
        if (freeze_en && drive_n == freeze_at) nq[0] = bank_q[0];
        drive_n <= drive_n + 1;
      end
      bank_q <= nq;
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [W-1:0] rule_j(logic [W-1:0] t, logic [W-1:0] q);
`ifdef JKLD_TOGGLE_EN
    return t ^ q;
`else
    return t & ~q;
`endif
  endfunction

  function automatic logic [W-1:0] rule_k(logic [W-1:0] t, logic [W-1:0] q);
`ifdef JKLD_TOGGLE_EN
    return t ^ q;
`else
    return ~t & q;
`endif
  endfunction

  // Outcome model: mode 0 healthy bank, 1 feedback stuck at 8'h01, 2 bit 0 fails on first drive only.
  function automatic exp_t model(logic [W-1:0] t, logic [W-1:0] q0, int mode, int acc);
    exp_t e;
    logic [W-1:0] after;
    e.acc = acc; e.is_err = 0; e.retries = 0; e.lat = 2; e.fin = t;
    if (mode == 1) begin
      e.fin = 8'h01;
      if (t != 8'h01) begin
        e.is_err = 1; e.retries = MR; e.lat = 2 * (MR + 1);
      end
    end else if (mode == 2) begin
      after = t;
      if (t != q0) after[0] = q0[0];
      if (after != t) begin
        e.retries = 1; e.lat = 4;
      end
    end
    return e;
  endfunction

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (!RST) begin
      if (!busy) chk("jk_hold_idle", {J, K}, 16'h0);
      else if ((J | K) != '0) begin
        chk("drive_J", J, rule_j(cur_tgt, q_fb));
        chk("drive_K", K, rule_k(cur_tgt, q_fb));
      end
      if (done || err) begin
        if (sb.size() == 0) chk("unexpected_end", 1, 0);
        else begin
          e = sb.pop_front();
          chk("end_err", err, e.is_err);
          chk("end_done", done, !e.is_err);
          chk("retry_cnt", retry_cnt, e.retries);
          chk("latency", cyc - e.acc, e.lat);
          chk("q_final", q_fb, e.fin);
          chk("ready_at_end", {busy, din_ready}, 2'b01);
        end
      end
    end
  end

  task automatic set_bank(input logic [W-1:0] v);
    load_val = v;
    load_req = ~load_req;
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic [W-1:0] t, input bit push, input int mode);
    logic [W-1:0] q0;
    int n;
    stuck = (mode == 1);
    freeze_en = (mode == 2);
    freeze_at = drive_n;
    cur_tgt = t; din = t; din_valid = 1'b1;
    n = 0;
    while (!din_ready && n < 100) begin @(posedge CLK); #1; n++; end
    if (!din_ready) chk("accept_timeout", 1, 0);
    q0 = q_fb;
    @(posedge CLK); #1;
    din_valid = 1'b0;
    din = W'($urandom);
    if (push) sb.push_back(model(t, q0, mode, cyc));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin @(posedge CLK); #1; n++; end
    if (sb.size() != 0 || busy) chk("op_timeout", 1, 0);
    @(posedge CLK); #1;
    stuck = 1'b0; freeze_en = 1'b0;
  endtask

  initial begin
    int acc1, acc2, n;
    logic [W-1:0] q0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", din_ready, 1); chk("rst_busy", busy, 0); chk("rst_J", J, 0);
    chk("rst_K", K, 0); chk("rst_done_err", {done, err}, 0); chk("rst_retry", retry_cnt, 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Reset asserted while excitation is on the bank pins.
    set_bank(8'h00);
    send(8'h0F, 0, 0);
    chk("pre_rst_J", J, 8'h0F);
    #1 RST = 1'b1;
    #1;
    chk("arst_J", J, 0); chk("arst_K", K, 0); chk("arst_busy", busy, 0);
    chk("arst_retry", retry_cnt, 0); chk("arst_ready", din_ready, 1);
    @(posedge CLK); #1; RST = 1'b0;
    @(posedge CLK); #1;
    chk("bank_after_rst", bank_q, 8'h00);

    set_bank(8'h00);
    send(8'hA5, 1, 0);
    chk("A5_J", J, 8'hA5);
`ifdef JKLD_TOGGLE_EN
    chk("A5_K", K, 8'hA5);
`else
    chk("A5_K", K, 8'h00);
`endif
    wait_idle();

    set_bank(8'hFF);
    send(8'h3C, 1, 0);
`ifdef JKLD_TOGGLE_EN
    chk("3C_J", J, 8'hC3);
`else
    chk("3C_J", J, 8'h00);
`endif
    chk("3C_K", K, 8'hC3);
    wait_idle();

    set_bank(8'h00);
    send(8'h80, 1, 1);
    wait_idle();
    chk("stuck_retry_hold", retry_cnt, MR);

    set_bank(8'h00);
    send(8'h81, 1, 2);
    wait_idle();

    // Back-to-back with din_valid held high; din wiggles while busy.
    set_bank(8'h00);
    cur_tgt = 8'h11; din = 8'h11; din_valid = 1'b1;
    q0 = q_fb;
    @(posedge CLK); #1;
    acc1 = cyc;
    sb.push_back(model(8'h11, q0, 0, acc1));
    n = 0;
    while (busy && n < 20) begin din = W'($urandom); @(posedge CLK); #1; n++; end
    din = 8'h22; cur_tgt = 8'h22;
    q0 = q_fb;
    @(posedge CLK); #1;
    acc2 = cyc;
    chk("b2b_busy", busy, 1);
    chk("b2b_gap", acc2 - acc1, 3);
    sb.push_back(model(8'h22, q0, 0, acc2));
    din_valid = 1'b0;
    wait_idle();
    chk("b2b_bank", bank_q, 8'h22);

    for (int i = 0; i < 40; i++) begin
      int mode, r;
      r = $urandom_range(0, 9);
      mode = (r < 7) ? 0 : (r == 7) ? 1 : 2;
      if ($urandom_range(0, 2) == 0) set_bank(W'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
      send(W'($urandom), 1, mode);
      wait_idle();
    end

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jk_reg_loader.md
# jk_reg_loader

Write-side controller for a bank of negedge-clocked JK flip-flops. Accepts a target word over a valid/ready handshake and computes per-bit J/K excitation from the bank's current Q feedback. Drives that excitation for exactly one cycle, then reads the bank back to confirm the load, retrying up to a fixed limit. Sits between a register-write source and any JK storage bank in the design.

## Interface
- WIDTH, 8, bits in target word and JK bank
- MAX_RETRY, 3, extra drive attempts after a failed readback (0..15)
- CLK  input  1  clock; this block acts on posedge, the JK bank on negedge
- RST  input  1  reset, asynchronous, active-high
- din  input  WIDTH  target value
- din_valid  input  1  target present
- din_ready  output  1  high only in IDLE
- q_fb  input  WIDTH  Q outputs of the JK bank
- J  output  WIDTH  J drive to bank, registered
- K  output  WIDTH  K drive to bank, registered
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse: readback matched target
- err  output  1  one-cycle pulse: retries exhausted, readback still mismatched
- retry_cnt  output  4  retries used by current/last operation

## Operation
- States: IDLE, DRIVE, CHECK.
- IDLE:
  - J=K=0 (hold).
  - On din_valid && din_ready, latch din into target, clear retry_cnt, load J/K from the excitation rule using target and q_fb, go to DRIVE.
- DRIVE: J/K held for this one cycle. At the next posedge, J=K=0 and the state goes to CHECK.
- CHECK: compare q_fb with target.
  - Equal: pulse done, go to IDLE.
  - Unequal and retry_cnt < MAX_RETRY: retry_cnt+1, reload J/K from the current q_fb, go to DRIVE.
  - Unequal and retry_cnt == MAX_RETRY: pulse err, go to IDLE.
- Excitation rule (default, minimal activity): J = target & ~q_fb, K = ~target & q_fb. Bits already correct get J=K=0.
- J and K are never both 1 on a bit in the default build.
- din is ignored outside IDLE. A new din is not sampled on the cycle that done or err is pulsed; it is sampled from the following posedge.
- MAX_RETRY=0: a single attempt, then done or err.
- retry_cnt saturates at MAX_RETRY and holds after the operation ends until the next accept.
- Reset (any state, including mid-DRIVE): state=IDLE, J=0, K=0, done=0, err=0, busy=0, retry_cnt=0, din_ready=1. Target is cleared to 0. The bank sees hold immediately.

## Timing
- Accept at posedge t0. J/K are valid from t0 to t1. The bank updates at the negedge inside that cycle.
- At posedge t1: J=K=0, state CHECK. At posedge t2: compare.
- Success on first attempt: done high t2..t3, din_ready high again from t2, next accept no earlier than t3.
- Each retry adds 2 cycles. Worst case err pulse is at t0 + 2·(MAX_RETRY+1).
- busy rises at t0 and falls at the edge that pulses done or err.
- q_fb must be stable from the bank negedge until the following posedge. No synchronizer is included.

## Configuration
- JKLD_TOGGLE_EN defined: the excitation becomes toggle form, J = K = target ^ q_fb. Bits needing change toggle; others hold. J=K=1 occurs by design.
- JKLD_TOGGLE_EN undefined: the set/reset form in Operation is used.
- The handshake, FSM, timing and retry behaviour are identical in both builds.

## Test plan
- Reset mid-DRIVE with J=8'h0F: J, K, busy and retry_cnt read 0 asynchronously and din_ready=1. After release, the bank Q is unchanged from its pre-edge value.
- Bank Q=8'h00, din=8'hA5: in the DRIVE cycle J=8'hA5, K=8'h00; done pulses at t0+2 and retry_cnt=0. Toggle build: J=K=8'hA5.
- Bank Q=8'hFF, din=8'h3C: J=8'h00, K=8'hC3; Q reads 8'h3C at t2 and done pulses.
- q_fb forced stuck at 8'h01, din=8'h80, MAX_RETRY=3: three retries occur, then err pulses at t0+8 with retry_cnt=3 and done never asserts.
- Bank with bit 0 stuck on the first attempt only: one retry, where J/K are recomputed from the new q_fb. done pulses at t0+4 and retry_cnt=1.
- Back-to-back din_valid held high with 8'h11 then 8'h22: the second accept occurs at t3. din changes while busy are ignored, and the bank ends at 8'h22.
